hpm_counter_bank: RTL and testbench
===================================

Name: hpm_counter_bank

Overview:
Parametrised machine-mode hardware performance monitor bank that sits beside the csr unit in the core.
- Implements NUM_COUNTERS event counters (mhpmcounter3+, mhpmcounter3h+), their event selectors (mhpmevent3+) and mcountinhibit.
- The csr unit forwards CSR reads and writes to this bank; the pipeline supplies event strobes.
- Generalises the single minstret-style counter to N counters of configurable width, with event selection, inhibit and overflow signalling.

Parameters:
NUM_COUNTERS, 4, number of counters implemented, 1..29, mapped to indices 3..3+NUM_COUNTERS-1
COUNTER_WIDTH, 64, implemented counter bits, 33..64
NUM_EVENTS, 8, width of events_i, 1..255

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
ce_i  input  1  pipeline clock enable; counting only when 1
durdur_i  input  1  pipeline stall; counting suppressed when 1
events_i  input  NUM_EVENTS  single-cycle event strobes; bit k-1 is event code k
csr_index_i  input  12  CSR address
csr_re_i  input  1  CSR read access
csr_we_i  input  1  CSR write strobe; csr_wdata_i is the final value after RW/RS/RC resolution
csr_wdata_i  input  32  write data
csr_rdata_o  output  32  read data, combinational from csr_index_i
csr_hit_o  output  1  csr_index_i maps to an implemented register of this bank
overflow_irq_o  output  1  overflow interrupt request (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - all counters, selectors, mcountinhibit and overflow flags go to 0
  - csr_rdata_o=0 unless indexed
  - overflow_irq_o=0
- Address map:
  - mcountinhibit 0x320
  - mhpmevent(3+i) 0x323+i
  - mhpmcounter(3+i) 0xB03+i
  - mhpmcounter(3+i)h 0xB83+i
  - csr_hit_o=1 only for these addresses, for i<NUM_COUNTERS; all others give hit=0 and rdata=0.
- Read path:
  - combinational, zero latency
  - returns the register value before this cycle's update
  - unimplemented counter bits (>=COUNTER_WIDTH) read 0
- Increment condition for counter i: ce_i & ~durdur_i & ~mcountinhibit[3+i] & sel_i!=0 & events_i[sel_i-1]. Adds exactly 1 per cycle.
- Selector WARL:
  - a write of value v in 1..NUM_EVENTS stores v; any other v stores 0
  - 0 means never count
- mcountinhibit: bits 3..3+NUM_COUNTERS-1 are writable; all other bits read 0.
- Counter writes:
  - a low-half write replaces bits 31:0 and keeps the upper bits
  - a high-half write replaces bits COUNTER_WIDTH-1:32; wdata bits above the width are ignored
- Write vs increment, same counter, same cycle: the write wins and the increment is dropped (no +1 after write).
- Wrap: a counter at all-ones (COUNTER_WIDTH bits) that increments becomes 0 and raises the overflow event for i.
- Writes are accepted regardless of ce_i/durdur_i. csr_re_i has no side effects.
- Reset mid-count: all state clears immediately; the first increment is possible in the first cycle after rst deasserts.

Optional Feature:
Macro HPM_OVERFLOW_IRQ_EN.
- Defined:
  - sticky register mhpmovf at 0x7C0, bit 3+i set on wrap of counter i
  - a write clears bits where wdata=1 (W1C); a simultaneous wrap on the same bit wins (stays set)
  - overflow_irq_o = OR of mhpmovf bits, registered, so 1 cycle after the flag sets
- Undefined:
  - no flag storage; 0x7C0 gives hit=0
  - overflow_irq_o tied 0; wrap is silent

Decomposition:
- Shared define header carries the CSR addresses alongside the existing MCAUSE-style defines: MCOUNTINHIBIT, MHPMEVENT3, MHPMCOUNTER3, MHPMCOUNTER3H, MHPMOVF.
- One sub-module, hpm_counter_slot, holds one counter, its selector, write/increment priority and wrap detect. It is instantiated NUM_COUNTERS times via generate; the bank owns the address decode, read mux, inhibit register and overflow flags.

Test Plan:
- Reset, then write 0x323=2, pulse events_i[1] for 5 cycles with ce_i=1, durdur_i=0 -> 0xB03 reads 5, 0xB83 reads 0.
- Same setup with durdur_i=1 for 2 of the 5 cycles, then set mcountinhibit bit 3 -> count is 3, and stays 3 under further events.
- Write 0x324=NUM_EVENTS+1 -> reads 0; write 0xB04=0xFFFFFFFF and 0xB84=0xFFFFFFFF with counter 4 selecting an active event -> next cycle reads 0/0. With HPM_OVERFLOW_IRQ_EN, mhpmovf bit 4=1 and overflow_irq_o=1 one cycle later; writing 0x10 to 0x7C0 clears both.
- Write 0xB03=0x100 in the same cycle as an event hit -> reads 0x100, not 0x101.
- COUNTER_WIDTH=40: write 0xB83=0xFFFFFFFF -> reads 0x000000FF. Read 0xB03+NUM_COUNTERS -> csr_hit_o=0, csr_rdata_o=0.
- Assert rst asynchronously mid-count -> all counters, selectors and overflow_irq_o read 0 before the next clk edge.

Source files
------------

// File: rtl/hpm_counter_bank_pkg.sv
// ---------------------------------------------------------------------------
// hpm_counter_bank_pkg
// Shared CSR address map and helpers for the machine-mode hardware
// performance monitor bank. Holds the CSR addresses (next to the existing
// trap-related addresses), the register-region decode type and the WARL
// helper for the event selectors.
// No ports (package).
// ---------------------------------------------------------------------------
package hpm_counter_bank_pkg;

   // Existing machine-mode CSR addresses used by the csr unit.
   localparam logic [11:0] MSTATUS       = 12'h300;
   localparam logic [11:0] MCAUSE        = 12'h342;
   localparam logic [11:0] MINSTRET      = 12'hB02;

   // Performance monitor CSR addresses (first of each block).
   localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] MHPMEVENT3    = 12'h323;
   localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] MHPMOVF       = 12'h7C0;

   // Selector storage width: enough for event codes up to 255.
   localparam int SEL_W = 8;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_INHIBIT,
      REG_EVENT,
      REG_CNT_LO,
      REG_CNT_HI,
      REG_OVF
   } hpm_reg_e;

   typedef struct packed {
      hpm_reg_e   kind;
      logic [4:0] slot;   // counter index within the bank (0 = mhpmcounter3)
   } hpm_decode_t;

   // Map a CSR address onto a register region and counter slot.
   // Offsets are unsigned, so addresses below a block base wrap to large
   // values and fall out of range naturally.
   function automatic hpm_decode_t hpm_decode(input logic [11:0] addr,
                                              input int          num_counters,
                                              input bit          ovf_en);
      hpm_decode_t d;
      logic [11:0] off_ev;
      logic [11:0] off_lo;
      logic [11:0] off_hi;
      off_ev = addr - MHPMEVENT3;
      off_lo = addr - MHPMCOUNTER3;
      off_hi = addr - MHPMCOUNTER3H;
      d.kind = REG_NONE;
      d.slot = '0;
      if (addr == MCOUNTINHIBIT) begin
         d.kind = REG_INHIBIT;
      end else if (ovf_en && (addr == MHPMOVF)) begin
         d.kind = REG_OVF;
      end else if (int'(off_ev) < num_counters) begin
         d.kind = REG_EVENT;
         d.slot = off_ev[4:0];
      end else if (int'(off_lo) < num_counters) begin
         d.kind = REG_CNT_LO;
         d.slot = off_lo[4:0];
      end else if (int'(off_hi) < num_counters) begin
         d.kind = REG_CNT_HI;
         d.slot = off_hi[4:0];
      end
      return d;
   endfunction

   // Event selector legalisation: only implemented event codes are kept,
   // anything else collapses to 0 (never count).
   function automatic logic [SEL_W-1:0] sel_warl(input logic [31:0] v,
                                                 input int          num_events);
      if ((v >= 32'd1) && (v <= 32'(num_events))) begin
         return v[SEL_W-1:0];
      end
      return '0;
   endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// ---------------------------------------------------------------------------
// hpm_counter_bank_if
// CSR access bus between the csr unit (master) and the performance monitor
// bank (slave).
//   csr_index_i  12  CSR address (also selects the read data)
//   csr_re_i      1  read access marker, no side effects
//   csr_we_i      1  write strobe, csr_wdata_i already RW/RS/RC resolved
//   csr_wdata_i  32  write data
//   csr_rdata_o  32  combinational read data for csr_index_i
//   csr_hit_o     1  csr_index_i maps onto a register of the bank
// Handshake: there is no backpressure. csr_we_i acts as valid with an
// implicit ready of 1, so every cycle with csr_we_i=1 commits one write at
// the next clock edge. Reads are combinational and complete in the same
// cycle; csr_hit_o qualifies csr_rdata_o.
// ---------------------------------------------------------------------------
interface hpm_counter_bank_if;
   logic [11:0] csr_index_i;
   logic        csr_re_i;
   logic        csr_we_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        csr_hit_o;

   modport master (
      output csr_index_i, csr_re_i, csr_we_i, csr_wdata_i,
      input  csr_rdata_o, csr_hit_o
   );

   modport slave (
      input  csr_index_i, csr_re_i, csr_we_i, csr_wdata_i,
      output csr_rdata_o, csr_hit_o
   );
endinterface

// File: rtl/hpm_counter_slot.sv
// ---------------------------------------------------------------------------
// hpm_counter_slot
// One performance counter with its event selector. Resolves CSR write vs
// increment priority (write wins) and flags the wrap from all-ones to zero.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   count_en   global enable already qualified by ce, stall and inhibit
//   events     event strobes, bit k-1 is event code k
//   sel_we     write strobe for the selector
//   lo_we      write strobe for counter bits 31:0
//   hi_we      write strobe for counter bits COUNTER_WIDTH-1:32
//   wdata      CSR write data
//   sel        current selector value
//   count      current counter value
//   wrap       counter wraps at the coming clock edge
// ---------------------------------------------------------------------------
module hpm_counter_slot
   import hpm_counter_bank_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64,
   parameter int NUM_EVENTS    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     count_en,
   input  logic [NUM_EVENTS-1:0]    events,
   input  logic                     sel_we,
   input  logic                     lo_we,
   input  logic                     hi_we,
   input  logic [31:0]              wdata,
   output logic [SEL_W-1:0]         sel,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     wrap
);

   logic [SEL_W-1:0]         sel_q;
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic                     ev_hit;
   logic                     inc;

   // Selected event strobe; selector 0 matches no event.
   always_comb begin
      ev_hit = 1'b0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
         if (sel_q == SEL_W'(k + 1)) ev_hit = events[k];
      end
   end

   // A CSR write to either half of this counter swallows the increment.
   assign inc  = count_en & ev_hit & ~(lo_we | hi_we);
   assign wrap = inc & (&cnt_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= '0;
         cnt_q <= '0;
      end else begin
         if (sel_we) sel_q <= sel_warl(wdata, NUM_EVENTS);
         if (lo_we) begin
            cnt_q <= {cnt_q[COUNTER_WIDTH-1:32], wdata};
         end else if (hi_we) begin
            // wdata bits above the implemented width are dropped.
            cnt_q <= {wdata[COUNTER_WIDTH-33:0], cnt_q[31:0]};
         end else if (inc) begin
            cnt_q <= cnt_q + COUNTER_WIDTH'(1);
         end
      end
   end

   assign sel   = sel_q;
   assign count = cnt_q;

   // High write-data bits are unused when the counter is narrower than 64.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

endmodule

// File: rtl/hpm_counter_bank.sv
// ---------------------------------------------------------------------------
// hpm_counter_bank
// Machine-mode hardware performance monitor bank: NUM_COUNTERS event
// counters (mhpmcounter3+/mhpmcounter3h+), their selectors (mhpmevent3+),
// mcountinhibit and optional overflow flags. Owns the address decode, read
// mux and inhibit register; each counter lives in an hpm_counter_slot.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ce_i            pipeline clock enable, counting only when 1
//   durdur_i        pipeline stall, counting suppressed when 1
//   events_i        single-cycle event strobes, bit k-1 is event code k
//   csr             CSR access bus (slave side)
//   overflow_irq_o  overflow interrupt request
// Build option: define HPM_OVERFLOW_IRQ_EN to add the sticky mhpmovf flag
// register at 0x7C0 and a registered overflow interrupt. Without it the
// wrap is silent, 0x7C0 does not hit and overflow_irq_o is 0.
// ---------------------------------------------------------------------------
module hpm_counter_bank
   import hpm_counter_bank_pkg::*;
#(
   parameter int NUM_COUNTERS  = 4,
   parameter int COUNTER_WIDTH = 64,
   parameter int NUM_EVENTS    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_i,
   input  logic                  durdur_i,
   input  logic [NUM_EVENTS-1:0] events_i,
   hpm_counter_bank_if.slave     csr,
   output logic                  overflow_irq_o
);

`ifdef HPM_OVERFLOW_IRQ_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   hpm_decode_t              dec;
   logic                     count_en;
   logic [NUM_COUNTERS-1:0]  inhibit_q;
   logic [NUM_COUNTERS-1:0]  sel_we;
   logic [NUM_COUNTERS-1:0]  lo_we;
   logic [NUM_COUNTERS-1:0]  hi_we;
   logic [NUM_COUNTERS-1:0]  wrap;
   logic [NUM_COUNTERS-1:0]  ovf_flags;
   logic [SEL_W-1:0]         sel [NUM_COUNTERS];
   logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
   logic [SEL_W-1:0]         sel_rd;
   logic [63:0]              cnt_rd;

   assign dec      = hpm_decode(csr.csr_index_i, NUM_COUNTERS, OVF_EN);
   assign count_en = ce_i & ~durdur_i;

   // Per-slot write strobes.
   always_comb begin
      sel_we = '0;
      lo_we  = '0;
      hi_we  = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (csr.csr_we_i && (dec.slot == 5'(i))) begin
            sel_we[i] = (dec.kind == REG_EVENT);
            lo_we[i]  = (dec.kind == REG_CNT_LO);
            hi_we[i]  = (dec.kind == REG_CNT_HI);
         end
      end
   end

   // mcountinhibit: only bits 3..3+NUM_COUNTERS-1 have storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inhibit_q <= '0;
      end else if (csr.csr_we_i && (dec.kind == REG_INHIBIT)) begin
         inhibit_q <= csr.csr_wdata_i[3 +: NUM_COUNTERS];
      end
   end

   for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slot
      hpm_counter_slot #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .NUM_EVENTS    (NUM_EVENTS)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .count_en (count_en & ~inhibit_q[i]),
         .events   (events_i),
         .sel_we   (sel_we[i]),
         .lo_we    (lo_we[i]),
         .hi_we    (hi_we[i]),
         .wdata    (csr.csr_wdata_i),
         .sel      (sel[i]),
         .count    (cnt[i]),
         .wrap     (wrap[i])
      );
   end

`ifdef HPM_OVERFLOW_IRQ_EN
   logic [NUM_COUNTERS-1:0] ovf_q;
   logic [NUM_COUNTERS-1:0] ovf_clr;
   logic                    irq_q;

   assign ovf_clr = (csr.csr_we_i && (dec.kind == REG_OVF))
                    ? csr.csr_wdata_i[3 +: NUM_COUNTERS] : '0;

   // W1C clear first, then set: a wrap in the same cycle keeps the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q & ~ovf_clr) | wrap;
         irq_q <= |ovf_q;
      end
   end

   assign ovf_flags      = ovf_q;
   assign overflow_irq_o = irq_q;
`else
   assign ovf_flags      = '0;
   assign overflow_irq_o = 1'b0;

   logic unused_wrap;
   assign unused_wrap = ^wrap;
`endif

   // Read mux: pick the addressed slot, then the register within it.
   always_comb begin
      sel_rd = '0;
      cnt_rd = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (dec.slot == 5'(i)) begin
            sel_rd = sel[i];
            cnt_rd = 64'(cnt[i]);
         end
      end
   end

   always_comb begin
      csr.csr_hit_o   = (dec.kind != REG_NONE);
      csr.csr_rdata_o = '0;
      case (dec.kind)
         REG_INHIBIT: csr.csr_rdata_o = 32'({inhibit_q, 3'b000});
         REG_EVENT:   csr.csr_rdata_o = 32'(sel_rd);
         REG_CNT_LO:  csr.csr_rdata_o = cnt_rd[31:0];
         REG_CNT_HI:  csr.csr_rdata_o = cnt_rd[63:32];
         REG_OVF:     csr.csr_rdata_o = 32'({ovf_flags, 3'b000});
         default:     csr.csr_rdata_o = '0;
      endcase
   end

   // Reads have no side effects, so the read marker is not needed.
   logic unused_re;
   assign unused_re = csr.csr_re_i;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_hpm_counter_bank
// Directed steps followed by randomized traffic, checked against a
// behavioural model of the counter bank (arrays of integer counters, plain
// arithmetic wrap at 2**COUNTER_WIDTH). Inputs change after the falling
// edge; outputs are sampled one time unit later.
// ---------------------------------------------------------------------------
module tb_hpm_counter_bank;
   localparam int NC = 4;
   localparam int CW = 40;
   localparam int NE = 8;
   localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;
   localparam int unsigned     NMASK = (32'd1 << NC) - 32'd1;
`ifdef HPM_OVERFLOW_IRQ_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          durdur;
   logic [NE-1:0] events;
   logic          irq;

   hpm_counter_bank_if csr_if ();

   hpm_counter_bank #(
      .NUM_COUNTERS  (NC),
      .COUNTER_WIDTH (CW),
      .NUM_EVENTS    (NE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ce_i           (ce),
      .durdur_i       (durdur),
      .events_i       (events),
      .csr            (csr_if.slave),
      .overflow_irq_o (irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   longint unsigned m_cnt [NC];
   int unsigned     m_sel [NC];
   int unsigned     m_inh;   // bit i = mcountinhibit bit 3+i
   int unsigned     m_ovf;   // bit i = mhpmovf bit 3+i
   bit              m_irq;

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = 0;
         m_sel[i] = 0;
      end
      m_inh = 0;
      m_ovf = 0;
      m_irq = 1'b0;
   endfunction

   // One clock edge worth of behaviour, from the currently driven inputs.
   function automatic void model_step();
      int unsigned wrapv;
      int unsigned a;
      int unsigned d;
      bit          we;
      bit          irq_next;
      if (rst) begin
         model_reset();
         return;
      end
      a  = 32'(csr_if.csr_index_i);
      d  = csr_if.csr_wdata_i;
      we = csr_if.csr_we_i;
      wrapv = 0;
      for (int i = 0; i < NC; i++) begin
         bit ev;
         ev = ce && !durdur && (((m_inh >> i) & 1) == 0) && (m_sel[i] != 0)
              && events[m_sel[i] - 1];
         if (we && a == 32'hB03 + i) begin
            m_cnt[i] = ((m_cnt[i] >> 32) << 32) | longint'(d);
         end else if (we && a == 32'hB83 + i) begin
            m_cnt[i] = ((longint'(d) << 32) | (m_cnt[i] & 64'hFFFF_FFFF)) & CMASK;
         end else if (ev) begin
            if (m_cnt[i] == CMASK) begin
               m_cnt[i] = 0;
               wrapv |= (32'd1 << i);
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
         if (we && a == 32'h323 + i) m_sel[i] = (d >= 1 && d <= NE) ? d : 0;
      end
      if (we && a == 32'h320) m_inh = (d >> 3) & NMASK;
      irq_next = (m_ovf != 0);
      if (OVF_EN) begin
         if (we && a == 32'h7C0) m_ovf &= ~((d >> 3) & NMASK);
         m_ovf |= wrapv;
         m_irq = irq_next;
      end
   endfunction

   function automatic bit model_hit(input int unsigned a);
      if (a == 32'h320) return 1'b1;
      if (OVF_EN && a == 32'h7C0) return 1'b1;
      for (int i = 0; i < NC; i++) begin
         if (a == 32'h323 + i || a == 32'hB03 + i || a == 32'hB83 + i) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_rd(input int unsigned a);
      if (a == 32'h320) return m_inh << 3;
      if (OVF_EN && a == 32'h7C0) return m_ovf << 3;
      for (int i = 0; i < NC; i++) begin
         if (a == 32'h323 + i) return m_sel[i];
         if (a == 32'hB03 + i) return 32'(m_cnt[i] & 64'hFFFF_FFFF);
         if (a == 32'hB83 + i) return 32'(m_cnt[i] >> 32);
      end
      return 32'h0;
   endfunction

   // ---------------- scoreboard ----------------
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Read one address and compare data and hit with the model.
   task automatic check_rd(input int unsigned a);
      logic [31:0] e;
      csr_if.csr_index_i = a[11:0];
      csr_if.csr_re_i    = 1'b1;
      exp_q.push_back(model_rd(a));
      exp_q.push_back(32'(model_hit(a)));
      #1;
      e = exp_q.pop_front();
      chk($sformatf("rdata_%03h", a), csr_if.csr_rdata_o, e);
      e = exp_q.pop_front();
      chk($sformatf("hit_%03h", a), 32'(csr_if.csr_hit_o), e);
      csr_if.csr_re_i = 1'b0;
   endtask

   task automatic check_irq(input string tag);
      chk(tag, 32'(irq), 32'(m_irq));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      events           = '0;
      csr_if.csr_we_i  = 1'b0;
   endtask

   task automatic do_wr(input int unsigned a, input logic [31:0] d, input logic [NE-1:0] ev);
      csr_if.csr_index_i = a[11:0];
      csr_if.csr_wdata_i = d;
      csr_if.csr_we_i    = 1'b1;
      events             = ev;
      tick();
   endtask

   task automatic ev_cycle(input logic [NE-1:0] ev, input logic c, input logic s);
      ce     = c;
      durdur = s;
      events = ev;
      tick();
      ce     = 1'b1;
      durdur = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int unsigned pool [18];

   initial begin
      pool[0] = 32'h320;
      pool[1] = 32'h7C0;
      pool[2] = 32'h321;
      for (int i = 0; i <= NC; i++) begin
         pool[3 + 3*i] = 32'h323 + i;
         pool[4 + 3*i] = 32'hB03 + i;
         pool[5 + 3*i] = 32'hB83 + i;
      end

      rst                = 1'b1;
      ce                 = 1'b1;
      durdur             = 1'b0;
      events             = '0;
      csr_if.csr_index_i = '0;
      csr_if.csr_re_i    = 1'b0;
      csr_if.csr_we_i    = 1'b0;
      csr_if.csr_wdata_i = '0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      foreach (pool[k]) check_rd(pool[k]);
      check_irq("irq_reset");

      // Five hits of event 2 on counter 3.
      do_wr(32'h323, 32'd2, '0);
      for (int c = 0; c < 5; c++) ev_cycle(8'b0000_0010, 1'b1, 1'b0);
      check_rd(32'hB03);
      chk("plan_cnt5", csr_if.csr_rdata_o, 32'd5);
      check_rd(32'hB83);

      // Stall on two of five cycles, then inhibit counter 3.
      do_wr(32'hB03, 32'd0, '0);
      for (int c = 0; c < 5; c++) ev_cycle(8'b0000_0010, 1'b1, (c == 1 || c == 3));
      check_rd(32'hB03);
      chk("plan_stall3", csr_if.csr_rdata_o, 32'd3);
      do_wr(32'h320, 32'h8, '0);
      for (int c = 0; c < 3; c++) ev_cycle(8'b0000_0010, 1'b1, 1'b0);
      check_rd(32'hB03);
      chk("plan_inhibit3", csr_if.csr_rdata_o, 32'd3);
      check_rd(32'h320);

      // Selector WARL and wrap of counter 4.
      do_wr(32'h324, NE + 1, '0);
      check_rd(32'h324);
      chk("plan_warl", csr_if.csr_rdata_o, 32'd0);
      do_wr(32'h324, 32'd3, '0);
      do_wr(32'hB04, 32'hFFFF_FFFF, '0);
      do_wr(32'hB84, 32'hFFFF_FFFF, '0);
      check_rd(32'hB84);
      ev_cycle(8'b0000_0100, 1'b1, 1'b0);
      check_rd(32'hB04);
      chk("plan_wrap_lo", csr_if.csr_rdata_o, 32'd0);
      check_rd(32'hB84);
      chk("plan_wrap_hi", csr_if.csr_rdata_o, 32'd0);
      check_rd(32'h7C0);
      check_irq("irq_wrap_edge");
      tick();
      check_irq("irq_wrap_next");
      chk("plan_irq_set", 32'(irq), 32'(OVF_EN));
      do_wr(32'h7C0, 32'h10, '0);
      check_rd(32'h7C0);
      tick();
      check_irq("irq_cleared");
      chk("plan_irq_clr", 32'(irq), 32'd0);

      // Write beats a simultaneous increment.
      do_wr(32'h320, 32'h0, '0);
      ce = 1'b1;
      do_wr(32'hB03, 32'h100, 8'b0000_0010);
      check_rd(32'hB03);
      chk("plan_wr_wins", csr_if.csr_rdata_o, 32'h100);

      // High half truncation and out-of-range index.
      do_wr(32'hB83, 32'hFFFF_FFFF, '0);
      check_rd(32'hB83);
      chk("plan_hi_trunc", csr_if.csr_rdata_o, 32'h0000_00FF);
      check_rd(32'hB03 + NC);
      chk("plan_oob_hit", 32'(csr_if.csr_hit_o), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         ce     = ($urandom_range(0, 3) != 0);
         durdur = ($urandom_range(0, 4) == 0);
         events = NE'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
               0:       d = $urandom;
               1:       d = 32'hFFFF_FFFF;
               2:       d = 32'hFFFF_FFFE;
               default: d = $urandom_range(0, NE + 2);
            endcase
            csr_if.csr_index_i = pool[$urandom_range(0, 17)][11:0];
            csr_if.csr_wdata_i = d;
            csr_if.csr_we_i    = 1'b1;
         end
         tick();
         check_rd(pool[$urandom_range(0, 17)]);
         check_irq("irq_rand");
      end

      // Asynchronous reset in the middle of counting.
      ce     = 1'b1;
      durdur = 1'b0;
      do_wr(32'h320, 32'h0, '0);
      do_wr(32'h323, 32'd1, '0);
      for (int c = 0; c < 3; c++) ev_cycle(8'b0000_0001, 1'b1, 1'b0);
      events = 8'b0000_0001;
      @(posedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      foreach (pool[k]) check_rd(pool[k]);
      check_irq("irq_async_rst");
      @(negedge clk);
      tick();
      rst = 1'b0;
      do_wr(32'h323, 32'd1, 8'b0000_0001);
      ev_cycle(8'b0000_0001, 1'b1, 1'b0);
      check_rd(32'hB03);
      chk("post_rst_cnt", csr_if.csr_rdata_o, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
